fpu_byte_if: RTL and testbench
==============================

FPU_BYTE_IF -- requirements
Module: fpu_byte_if

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: cycles allowed between start and cmd_end before the command is aborted.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-003 SHALL have port arst, input, 1 bit: asynchronous active-high reset.
REQ-004 SHALL have port cs, input, 1 bit: chip select from the CPU bus.
REQ-005 SHALL have port wr, input, 1 bit: write strobe, qualified by cs, one byte per cycle.
REQ-006 SHALL have port rd, input, 1 bit: read strobe, qualified by cs.
REQ-007 SHALL have port addr, input, 4 bits: register address.
REQ-008 SHALL have port data_in, input, 8 bits: write data.
REQ-009 SHALL have port data_out, output, 8 bits: read data.
REQ-010 SHALL have port irq, output, 1 bit: completion interrupt.
REQ-011 SHALL have port fpu_start, output, 1 bit: drives the FPU start input.
REQ-012 SHALL have ports fpu_a_operand and fpu_b_operand, outputs, 32 bits each: IEEE-754 single operands.
REQ-013 SHALL have port fpu_operation, output, type pa_fpu::e_fpu_op: selected operation.
REQ-014 SHALL have port fpu_result, input, 32 bits: FPU ieee_packet_out.
REQ-015 SHALL have port fpu_cmd_end, input, 1 bit: FPU end of command.

Function
REQ-016 Register map SHALL be: 0-3 A bytes (0 = LSB), 4-7 B bytes (4 = LSB), 8 op code in bits[3:0], 9 CMD/STATUS, A-D result bytes (A = LSB, read-only), E CTRL, F reads 0x00.
REQ-017 Writing 1 to CMD bit0 SHALL be the GO command.
REQ-018 STATUS bit0 SHALL read as busy, bit1 as done, bit2 as err_busy_wr, bit3 as timeout.
REQ-019 CTRL bit0 SHALL be irq_en (read/write); writing 1 to CTRL bit1 SHALL clear done, err_busy_wr and timeout.
REQ-020 FSM SHALL have states IDLE, RUN, CAPTURE.
REQ-021 GO in IDLE SHALL clear done/timeout, zero the watchdog, and move to RUN on the next edge.
REQ-022 fpu_start SHALL be 1 exactly while in RUN; it drops on the edge after fpu_cmd_end is sampled high.
REQ-023 In RUN with fpu_cmd_end=1, the FSM SHALL go to CAPTURE; CAPTURE SHALL latch fpu_result, set done and return to IDLE in 1 cycle.
REQ-024 In RUN, the watchdog SHALL increment each cycle; on reaching TIMEOUT_CYCLES without cmd_end it SHALL set timeout, leave the result unchanged and return to IDLE.
REQ-025 busy SHALL be 1 in RUN and CAPTURE.
REQ-026 Writes to addresses 0-9 while busy SHALL be ignored and SHALL set err_busy_wr; GO while busy SHALL NOT restart.
REQ-027 Operand and op registers SHALL drive fpu_a_operand, fpu_b_operand and fpu_operation continuously; op bits beyond the enum width are ignored.
REQ-028 irq SHALL equal irq_en AND (done OR timeout), registered.
REQ-029 data_out SHALL be combinational from addr when cs&rd, else 0x00; reads have no side effects.
REQ-030 If a CTRL clear and a completion occur in the same cycle, completion SHALL win: done ends at 1.

Reset
REQ-031 arst SHALL force, immediately: state IDLE, fpu_start 0, irq 0, all registers (operands, op, result, flags, irq_en, watchdog) 0, data_out 0.
REQ-032 arst asserted mid-RUN SHALL abort with no result capture; fpu_start SHALL deassert asynchronously.

Structure
REQ-033 Register address constants, STATUS/CTRL bit indices and the FSM state enum SHALL live in pa_fpu, alongside e_fpu_op.
REQ-034 Single module; no sub-modules; the FPU is instantiated by the parent, not inside this block.

Verification
REQ-035 Test 1: write A=3f800000, B=3f8ccccd, op=op_sub, GO -> fpu_start high until cmd_end; result bytes read D0 CC CC BD; done=1.
REQ-036 Test 2: with irq_en=1, run an op_add of 41800000 + 42000000 -> irq rises after CAPTURE; result is 42400000; a CTRL clear drops irq next cycle.
REQ-037 Test 3: a stub FPU that never asserts cmd_end, TIMEOUT_CYCLES=16 -> fpu_start drops after 16 RUN cycles; timeout=1; result stays 0.
REQ-038 Test 4: write to address 0 and issue GO while busy -> A unchanged, err_busy_wr=1, only one start pulse.
REQ-039 Test 5: assert arst mid-RUN -> fpu_start 0 without waiting for a clock edge; all STATUS bits 0 after release.
REQ-040 Test 6: cmd_end coincident with a CTRL clear write -> done=1 after the edge.

Source files
------------

// File: rtl/pa_fpu.sv
// Shared definitions for the FPU byte-wide bus interface: operation codes,
// register map, STATUS/CTRL bit positions and the sequencer state type.
package pa_fpu;

  typedef enum logic [1:0] {
    op_add = 2'd0,
    op_sub = 2'd1,
    op_mul = 2'd2,
    op_div = 2'd3
  } e_fpu_op;

  localparam int OP_W = $bits(e_fpu_op);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    CAPTURE = 2'd2
  } e_if_state;

  // Register map
  localparam logic [3:0] ADDR_A0   = 4'h0;
  localparam logic [3:0] ADDR_A3   = 4'h3;
  localparam logic [3:0] ADDR_B0   = 4'h4;
  localparam logic [3:0] ADDR_B3   = 4'h7;
  localparam logic [3:0] ADDR_OP   = 4'h8;
  localparam logic [3:0] ADDR_CMD  = 4'h9;
  localparam logic [3:0] ADDR_RES0 = 4'hA;
  localparam logic [3:0] ADDR_RES3 = 4'hD;
  localparam logic [3:0] ADDR_CTRL = 4'hE;

  // CMD / STATUS / CTRL bit positions
  localparam int CMD_GO       = 0;
  localparam int ST_BUSY      = 0;
  localparam int ST_DONE      = 1;
  localparam int ST_ERR_WR    = 2;
  localparam int ST_TIMEOUT   = 3;
  localparam int CTRL_IRQ_EN  = 0;
  localparam int CTRL_CLEAR   = 1;

endpackage

// File: rtl/fpu_byte_if.sv
// Byte-wide CPU register window in front of a single-precision FPU:
// collects operands and op code, sequences one FPU command, captures the
// result and reports status / interrupt, with a watchdog on the command.
module fpu_byte_if
  import pa_fpu::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        cs,
  input  logic        wr,
  input  logic        rd,
  input  logic [3:0]  addr,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        irq,
  output logic        fpu_start,
  output logic [31:0] fpu_a_operand,
  output logic [31:0] fpu_b_operand,
  output e_fpu_op     fpu_operation,
  input  logic [31:0] fpu_result,
  input  logic        fpu_cmd_end
);

  localparam int WD_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  e_if_state   state, state_next;
  logic [31:0] a_reg, b_reg, res_reg;
  logic [3:0]  op_reg;
  logic [WD_W-1:0] wd;
  logic        done, timeout, err_busy_wr, irq_en;
  logic        done_n, timeout_n, err_n, irq_en_n;
  logic        we, busy, ctrl_wr, clear, blocked;
  logic        go, capture, expire, wd_clr, wd_inc;

  assign we      = cs & wr;
  assign busy    = (state != IDLE);
  assign ctrl_wr = we && (addr == ADDR_CTRL);
  assign clear   = ctrl_wr && data_in[CTRL_CLEAR];
  assign blocked = we && busy && (addr <= ADDR_CMD);

  assign fpu_start     = (state == RUN);
  assign fpu_a_operand = a_reg;
  assign fpu_b_operand = b_reg;
  assign fpu_operation = e_fpu_op'(op_reg[OP_W-1:0]);

  // Sequencer state register; reset aborts any command in flight at once
  always_ff @(posedge clk or posedge arst) begin
    if (arst) state <= IDLE;
    else      state <= state_next;
  end

  // Sequencer next state plus the single-cycle events it raises
  always_comb begin
    state_next = state;
    go         = 1'b0;
    capture    = 1'b0;
    expire     = 1'b0;
    wd_clr     = 1'b0;
    wd_inc     = 1'b0;
    case (state)
      IDLE: begin
        if (we && (addr == ADDR_CMD) && data_in[CMD_GO]) begin
          go         = 1'b1;
          wd_clr     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        wd_inc = 1'b1;
        if (fpu_cmd_end) begin
          state_next = CAPTURE;
        end else if (wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
          expire     = 1'b1;
          state_next = IDLE;
        end
      end
      CAPTURE: begin
        capture    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Flag updates; a completion in the same cycle as a clear leaves the flag set
  always_comb begin
    done_n    = done;
    timeout_n = timeout;
    err_n     = err_busy_wr;
    irq_en_n  = irq_en;
    if (ctrl_wr) irq_en_n = data_in[CTRL_IRQ_EN];
    if (clear) begin
      done_n    = 1'b0;
      timeout_n = 1'b0;
      err_n     = 1'b0;
    end
    if (go) begin
      done_n    = 1'b0;
      timeout_n = 1'b0;
    end
    if (blocked) err_n = 1'b1;
    if (capture) done_n = 1'b1;
    if (expire)  timeout_n = 1'b1;
  end

  // Status flags and the interrupt, registered from their next values
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      done        <= 1'b0;
      timeout     <= 1'b0;
      err_busy_wr <= 1'b0;
      irq_en      <= 1'b0;
      irq         <= 1'b0;
    end else begin
      done        <= done_n;
      timeout     <= timeout_n;
      err_busy_wr <= err_n;
      irq_en      <= irq_en_n;
      irq         <= irq_en_n & (done_n | timeout_n);
    end
  end

  // Operand/op byte writes (idle only), result capture and the watchdog
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      op_reg  <= '0;
      res_reg <= '0;
      wd      <= '0;
    end else begin
      if (we && !busy) begin
        if (addr <= ADDR_A3)
          a_reg[{addr[1:0], 3'b000} +: 8] <= data_in;
        else if (addr <= ADDR_B3)
          b_reg[{addr[1:0], 3'b000} +: 8] <= data_in;
        else if (addr == ADDR_OP)
          op_reg <= data_in[3:0];
      end
      if (capture) res_reg <= fpu_result;
      if (wd_clr)      wd <= '0;
      else if (wd_inc) wd <= wd + 1'b1;
    end
  end

  // Read mux; purely combinational so reads never disturb state
  always_comb begin
    data_out = 8'h00;
    if (cs && rd) begin
      case (addr)
        4'h0, 4'h1, 4'h2, 4'h3: data_out = a_reg[{addr[1:0], 3'b000} +: 8];
        4'h4, 4'h5, 4'h6, 4'h7: data_out = b_reg[{addr[1:0], 3'b000} +: 8];
        ADDR_OP:   data_out = {4'h0, op_reg};
        ADDR_CMD:  data_out = {4'h0, timeout, err_busy_wr, done, busy};
        4'hA:      data_out = res_reg[7:0];
        4'hB:      data_out = res_reg[15:8];
        4'hC:      data_out = res_reg[23:16];
        ADDR_RES3: data_out = res_reg[31:24];
        ADDR_CTRL: data_out = {7'h00, irq_en};
        default:   data_out = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_byte_if.sv
// Directed self-checking bench for fpu_byte_if; the FPU is a bench-driven
// stub whose result and cmd_end are set by hand per step.
module tb_fpu_byte_if;
  import pa_fpu::*;

  logic        clk = 1'b0;
  logic        arst;
  logic        cs, wr, rd;
  logic [3:0]  addr;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        irq;
  logic        fpu_start;
  logic [31:0] fpu_a_operand, fpu_b_operand;
  e_fpu_op     fpu_operation;
  logic [31:0] fpu_result;
  logic        fpu_cmd_end;

  int n_asserts = 0;
  int n_fail    = 0;
  int start_count = 0;

  fpu_byte_if #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .arst(arst), .cs(cs), .wr(wr), .rd(rd), .addr(addr),
    .data_in(data_in), .data_out(data_out), .irq(irq),
    .fpu_start(fpu_start), .fpu_a_operand(fpu_a_operand),
    .fpu_b_operand(fpu_b_operand), .fpu_operation(fpu_operation),
    .fpu_result(fpu_result), .fpu_cmd_end(fpu_cmd_end)
  );

  always #5 clk = ~clk;

  // Count every rising edge of the start line to catch restarts
  always @(posedge fpu_start) start_count++;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus write, held across a single rising edge
  task automatic applyStimulus(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; addr = a; data_in = d;
    @(posedge clk);
    #1;
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic writeWord(input logic [3:0] base, input logic [31:0] w);
    for (int i = 0; i < 4; i++) applyStimulus(base + 4'(i), w[8*i +: 8]);
  endtask

  task automatic checkReg(input string tag, input logic [3:0] a, input logic [7:0] exp);
    logic [7:0] d;
    @(negedge clk);
    cs = 1'b1; rd = 1'b1; addr = a;
    #1;
    d = data_out;
    cs = 1'b0; rd = 1'b0;
    checkOutput(tag, {24'h0, d}, {24'h0, exp});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    int starts_before;
    arst = 1'b1; cs = 1'b0; wr = 1'b0; rd = 1'b0; addr = 4'h0; data_in = 8'h00;
    fpu_result = 32'h0; fpu_cmd_end = 1'b0;

    // Reset state
    tick(2);
    checkOutput("rst_start", {31'h0, fpu_start}, 32'h0);
    checkOutput("rst_irq", {31'h0, irq}, 32'h0);
    checkOutput("rst_a", fpu_a_operand, 32'h0);
    checkReg("rst_status", ADDR_CMD, 8'h00);
    @(negedge clk) arst = 1'b0;

    // Test 1: 1.0 - 1.1
    $display("[TB] test 1: op_sub");
    writeWord(ADDR_A0, 32'h3f800000);
    writeWord(ADDR_B0, 32'h3f8ccccd);
    applyStimulus(ADDR_OP, 8'h01);
    checkOutput("t1_a", fpu_a_operand, 32'h3f800000);
    checkOutput("t1_b", fpu_b_operand, 32'h3f8ccccd);
    checkOutput("t1_op", 32'(fpu_operation), 32'(op_sub));
    applyStimulus(ADDR_CMD, 8'h01);
    checkOutput("t1_start_hi", {31'h0, fpu_start}, 32'h1);
    checkReg("t1_busy", ADDR_CMD, 8'h01);
    tick(2);
    checkOutput("t1_start_hold", {31'h0, fpu_start}, 32'h1);
    @(negedge clk);
    fpu_result = 32'hbdccccd0; fpu_cmd_end = 1'b1;
    tick(1);
    checkOutput("t1_start_drop", {31'h0, fpu_start}, 32'h0);
    @(negedge clk) fpu_cmd_end = 1'b0;
    #1;
    cs = 1'b1; rd = 1'b1; addr = ADDR_CMD; #1;
    checkOutput("t1_capture_busy", {24'h0, data_out}, 32'h01);
    cs = 1'b0; rd = 1'b0;
    tick(1);
    checkReg("t1_res0", 4'hA, 8'hD0);
    checkReg("t1_res1", 4'hB, 8'hCC);
    checkReg("t1_res2", 4'hC, 8'hCC);
    checkReg("t1_res3", 4'hD, 8'hBD);
    checkReg("t1_done", ADDR_CMD, 8'h02);
    checkOutput("t1_irq", {31'h0, irq}, 32'h0);
    @(negedge clk);
    addr = ADDR_CMD; cs = 1'b1; rd = 1'b0; #1;
    checkOutput("t1_rd_gated", {24'h0, data_out}, 32'h0);
    cs = 1'b0;

    // Test 2: 16 + 32 with interrupt
    $display("[TB] test 2: op_add with irq");
    applyStimulus(ADDR_CTRL, 8'h03);
    checkOutput("t2_irq_cleared", {31'h0, irq}, 32'h0);
    checkReg("t2_ctrl", ADDR_CTRL, 8'h01);
    writeWord(ADDR_A0, 32'h41800000);
    writeWord(ADDR_B0, 32'h42000000);
    applyStimulus(ADDR_OP, 8'h00);
    checkOutput("t2_op", 32'(fpu_operation), 32'(op_add));
    applyStimulus(ADDR_CMD, 8'h01);
    tick(2);
    checkOutput("t2_irq_run", {31'h0, irq}, 32'h0);
    @(negedge clk);
    fpu_result = 32'h42400000; fpu_cmd_end = 1'b1;
    tick(1);
    checkOutput("t2_irq_capture", {31'h0, irq}, 32'h0);
    @(negedge clk) fpu_cmd_end = 1'b0;
    tick(1);
    checkOutput("t2_irq_rise", {31'h0, irq}, 32'h1);
    checkReg("t2_res0", 4'hA, 8'h00);
    checkReg("t2_res2", 4'hC, 8'h40);
    checkReg("t2_res3", 4'hD, 8'h42);
    applyStimulus(ADDR_CTRL, 8'h03);
    checkOutput("t2_irq_drop", {31'h0, irq}, 32'h0);
    applyStimulus(ADDR_CTRL, 8'h00);

    // Test 3: watchdog with a silent FPU
    $display("[TB] test 3: timeout");
    @(negedge clk) arst = 1'b1;
    @(negedge clk) arst = 1'b0;
    applyStimulus(ADDR_CMD, 8'h01);
    cnt = 0;
    while (fpu_start && cnt < 100) begin
      tick(1);
      cnt++;
    end
    checkOutput("t3_run_cycles", 32'(cnt), 32'd16);
    checkReg("t3_status", ADDR_CMD, 8'h08);
    checkReg("t3_res0", 4'hA, 8'h00);
    checkReg("t3_res3", 4'hD, 8'h00);
    checkOutput("t3_irq", {31'h0, irq}, 32'h0);

    // Test 4: writes and GO while busy
    $display("[TB] test 4: busy write");
    applyStimulus(ADDR_CTRL, 8'h02);
    checkReg("t4_cleared", ADDR_CMD, 8'h00);
    applyStimulus(ADDR_A0, 8'h11);
    starts_before = start_count;
    applyStimulus(ADDR_CMD, 8'h01);
    applyStimulus(ADDR_A0, 8'h55);
    checkOutput("t4_a_kept", fpu_a_operand, 32'h00000011);
    checkReg("t4_err_busy", ADDR_CMD, 8'h05);
    applyStimulus(ADDR_CMD, 8'h01);
    @(negedge clk) fpu_cmd_end = 1'b1;
    @(negedge clk) fpu_cmd_end = 1'b0;
    tick(3);
    checkOutput("t4_start_low", {31'h0, fpu_start}, 32'h0);
    checkOutput("t4_one_pulse", 32'(start_count - starts_before), 32'd1);
    checkReg("t4_status", ADDR_CMD, 8'h06);

    // Test 5: asynchronous reset mid-command
    $display("[TB] test 5: reset mid-run");
    applyStimulus(ADDR_CTRL, 8'h02);
    applyStimulus(ADDR_CMD, 8'h01);
    tick(2);
    checkOutput("t5_running", {31'h0, fpu_start}, 32'h1);
    #1 arst = 1'b1;
    #1;
    checkOutput("t5_async_drop", {31'h0, fpu_start}, 32'h0);
    @(negedge clk) arst = 1'b0;
    checkReg("t5_status", ADDR_CMD, 8'h00);
    checkOutput("t5_a_zero", fpu_a_operand, 32'h0);

    // Test 6: clear racing with completion
    $display("[TB] test 6: clear vs completion");
    fpu_result = 32'h3f800000;
    applyStimulus(ADDR_CMD, 8'h01);
    tick(1);
    @(negedge clk);
    fpu_cmd_end = 1'b1; cs = 1'b1; wr = 1'b1; addr = ADDR_CTRL; data_in = 8'h02;
    tick(1);
    cs = 1'b0; wr = 1'b0;
    @(negedge clk) fpu_cmd_end = 1'b0;
    tick(1);
    checkReg("t6_done_a", ADDR_CMD, 8'h02);
    fpu_result = 32'h40000000;
    applyStimulus(ADDR_CMD, 8'h01);
    @(negedge clk) fpu_cmd_end = 1'b1;
    tick(1);
    @(negedge clk);
    fpu_cmd_end = 1'b0; cs = 1'b1; wr = 1'b1; addr = ADDR_CTRL; data_in = 8'h02;
    tick(1);
    cs = 1'b0; wr = 1'b0;
    checkReg("t6_done_b", ADDR_CMD, 8'h02);
    checkReg("t6_res3", 4'hD, 8'h40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
